// File: rtl/rx_serial_7o1.sv
`default_nettype none
// ============================================================================
//  Module   : rx_serial_7o1
//  Purpose  : Serial receiver for 7O1 frames (start, 7 data bits LSB first,
//             odd parity, stop). It synchronises the line and times each bit
//             from the start-bit mid-point. Results are held until the
//             consumer acknowledges them with limpa.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_serial_7o1 #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    input  logic       limpa,
    output logic [6:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic       erro_overrun,
    output logic [3:0] db_estado
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    c_IDX_LAST  = 3'd6;

    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        START        = 4'd1,
        DADOS        = 4'd2,
        PARIDADE     = 4'd3,
        STOP         = 4'd4,
        ARMAZENA     = 4'd5,
        ESPERA_LINHA = 4'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_rx_meta;
    logic            r_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [6:0]      r_shift;
    logic            r_par_bit;
    logic            r_stop_bit;

    logic [6:0]      r_dados;
    logic            r_tem_dado;
    logic            r_erro_paridade;
    logic            r_erro_stop;
    logic            r_erro_overrun;

    logic            w_cnt_clr;
    logic            w_cnt_run;
    logic            w_shift_en;
    logic            w_par_en;
    logic            w_stop_en;
    logic            w_store;
    logic            w_idx_clr;
    logic            w_half_done;
    logic            w_bit_done;

    assign w_half_done = (r_cnt == c_HALF_LAST);
    assign w_bit_done  = (r_cnt == c_BIT_LAST);

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= entrada_serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= OCIOSO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_run   = 1'b0;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_stop_en   = 1'b0;
        w_store     = 1'b0;
        w_idx_clr   = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (!r_rx_s) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_cnt_run = 1'b1;
                if (w_half_done) begin
                    w_cnt_clr = 1'b1;
                    w_idx_clr = 1'b1;
                    // A start bit that is high again at mid-point is a glitch
                    w_state_nxt = r_rx_s ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                w_cnt_run = 1'b1;
                if (w_bit_done) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = PARIDADE;
                    end
                end
            end
            PARIDADE: begin
                w_cnt_run = 1'b1;
                if (w_bit_done) begin
                    w_cnt_clr   = 1'b1;
                    w_par_en    = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                w_cnt_run = 1'b1;
                if (w_bit_done) begin
                    w_cnt_clr   = 1'b1;
                    w_stop_en   = 1'b1;
                    w_state_nxt = ARMAZENA;
                end
            end
            ARMAZENA: begin
                w_store = 1'b1;
                // A low stop bit may be a break; wait for the line to recover
                w_state_nxt = r_stop_bit ? OCIOSO : ESPERA_LINHA;
            end
            ESPERA_LINHA: begin
                if (r_rx_s) begin
                    w_state_nxt = OCIOSO;
                end
            end
            default: begin
                w_state_nxt = OCIOSO;
            end
        endcase
    end

    // Bit-timing counter: runs only while a frame is being timed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_run) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Data-bit index and LSB-first shift register (new bits enter at the top)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx   <= 3'd0;
            r_shift <= 7'd0;
        end else if (w_idx_clr) begin
            r_idx   <= 3'd0;
        end else if (w_shift_en) begin
            r_idx   <= r_idx + 3'd1;
            r_shift <= {r_rx_s, r_shift[6:1]};
        end
    end

    // Captured parity and stop bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_par_bit  <= 1'b0;
            r_stop_bit <= 1'b0;
        end else begin
            if (w_par_en) begin
                r_par_bit <= r_rx_s;
            end
            if (w_stop_en) begin
                r_stop_bit <= r_rx_s;
            end
        end
    end

    // Result registers; a completing frame takes priority over limpa
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dados         <= 7'd0;
            r_tem_dado      <= 1'b0;
            r_erro_paridade <= 1'b0;
            r_erro_stop     <= 1'b0;
            r_erro_overrun  <= 1'b0;
        end else if (w_store) begin
            r_dados         <= r_shift;
            r_tem_dado      <= 1'b1;
            r_erro_paridade <= ~^{r_shift, r_par_bit};
            r_erro_stop     <= ~r_stop_bit;
            r_erro_overrun  <= r_tem_dado | (r_erro_overrun & ~limpa);
        end else if (limpa) begin
            r_tem_dado      <= 1'b0;
            r_erro_overrun  <= 1'b0;
        end
    end

    assign dados_ascii   = r_dados;
    assign pronto        = w_store;
    assign tem_dado      = r_tem_dado;
    assign erro_paridade = r_erro_paridade;
    assign erro_stop     = r_erro_stop;
    assign erro_overrun  = r_erro_overrun;
    assign db_estado     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rx_serial_7o1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_serial_7o1
//  Purpose  : Scoreboard bench for rx_serial_7o1 with directed and random
//             7O1 frames driven at CLKS_PER_BIT = 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_serial_7o1;

    localparam int CPB = 4;

    logic       clock;
    logic       reset;
    logic       entrada_serial;
    logic       limpa;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro_paridade;
    logic       erro_stop;
    logic       erro_overrun;
    logic [3:0] db_estado;

    typedef struct packed {
        logic [6:0] d;
        logic       pe;
        logic       se;
        logic       ov;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   m_tem = 1'b0;
    bit   m_ovr = 1'b0;

    rx_serial_7o1 #(.CLKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .limpa          (limpa),
        .dados_ascii    (dados_ascii),
        .pronto         (pronto),
        .tem_dado       (tem_dado),
        .erro_paridade  (erro_paridade),
        .erro_stop      (erro_stop),
        .erro_overrun   (erro_overrun),
        .db_estado      (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one frame, one bit every CPB cycles; optionally register its expected result
    task automatic send_frame(input logic [6:0] d, input bit bad_par, input logic stop_b,
                              input bit do_push);
        logic       par;
        logic [9:0] bits;
        exp_t       e;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        if (bad_par) par = ~par;
        if (do_push) begin
            e.d  = d;
            e.pe = ($countones({d, par}) % 2 == 0);
            e.se = (stop_b == 1'b0);
            e.ov = m_ovr | m_tem;
            m_tem = 1'b1;
            m_ovr = e.ov;
            q.push_back(e);
        end
        bits = {stop_b, par, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            entrada_serial = bits[k];
            repeat (CPB) @(negedge clock);
        end
    endtask

    task automatic pulse_limpa();
        limpa = 1'b1;
        @(negedge clock);
        limpa = 1'b0;
        m_tem = 1'b0;
        m_ovr = 1'b0;
    endtask

    // Wait (bounded) for pronto at a falling edge; report a timeout as a failure
    task automatic wait_pronto(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (pronto === 1'b1) seen = 1'b1;
            else @(negedge clock);
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // Monitor: each pronto pops one expectation and checks the registers a cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (pronto === 1'b1) begin
                @(negedge clock);
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pronto_unexpected: pronto with no frame pending, dados=%h (t=%0t)",
                             dados_ascii, $time);
                end else begin
                    e = q.pop_front();
                    check("frame_result",
                          {20'd0, dados_ascii, tem_dado, erro_paridade, erro_stop, erro_overrun, pronto},
                          {20'd0, e.d, 1'b1, e.pe, e.se, e.ov, 1'b0});
                end
            end
        end
    end

    initial begin
        bit         saw_start;
        logic [10:0] snap;
        logic [6:0] rd;
        int         gap;

        reset          = 1'b0;
        entrada_serial = 1'b1;
        limpa          = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs",
              {20'd0, dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, erro_overrun},
              32'd0);
        check("reset_state", {28'd0, db_estado}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // 'A' with correct parity
        send_frame(7'h41, 1'b0, 1'b1, 1'b1);
        repeat (6) @(negedge clock);
        pulse_limpa();
        repeat (2) @(negedge clock);
        check("limpa_clears_tem", {30'd0, tem_dado, erro_overrun}, 32'd0);
        check("limpa_keeps_data", {25'd0, dados_ascii}, 32'h41);

        // 'C' with parity bit forced to 1
        send_frame(7'h43, 1'b1, 1'b1, 1'b1);
        repeat (6) @(negedge clock);
        pulse_limpa();

        // 0x55 with stop forced 0 and line held low
        send_frame(7'h55, 1'b0, 1'b0, 1'b1);
        entrada_serial = 1'b0;
        repeat (20) @(negedge clock);
        check("break_waits", {28'd0, db_estado}, 32'd6);
        entrada_serial = 1'b1;
        repeat (6) @(negedge clock);
        check("break_recovered", {28'd0, db_estado}, 32'd0);
        pulse_limpa();
        repeat (2) @(negedge clock);

        // One-cycle glitch on an idle line
        snap = {dados_ascii, tem_dado, erro_paridade, erro_stop, erro_overrun};
        entrada_serial = 1'b0;
        @(negedge clock);
        entrada_serial = 1'b1;
        saw_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (db_estado === 4'd1) saw_start = 1'b1;
            @(negedge clock);
        end
        check("glitch_enters_start", {31'd0, saw_start}, 32'd1);
        repeat (4) @(negedge clock);
        check("glitch_back_idle", {28'd0, db_estado}, 32'd0);
        check("glitch_outputs_kept",
              {21'd0, dados_ascii, tem_dado, erro_paridade, erro_stop, erro_overrun},
              {21'd0, snap});

        // Back-to-back frames with no acknowledge in between
        send_frame(7'h41, 1'b0, 1'b1, 1'b1);
        send_frame(7'h42, 1'b0, 1'b1, 1'b1);
        repeat (6) @(negedge clock);
        pulse_limpa();
        repeat (2) @(negedge clock);
        check("overrun_cleared", {30'd0, tem_dado, erro_overrun}, 32'd0);

        // limpa in the same cycle as the store, with data already held
        send_frame(7'h11, 1'b0, 1'b1, 1'b1);
        repeat (6) @(negedge clock);
        send_frame(7'h22, 1'b0, 1'b1, 1'b1);
        wait_pronto("pronto_timeout_same_cycle");
        limpa = 1'b1;
        @(negedge clock);
        limpa = 1'b0;
        repeat (3) @(negedge clock);
        check("limpa_vs_store", {30'd0, tem_dado, erro_overrun}, 32'h3);
        pulse_limpa();
        repeat (2) @(negedge clock);

        // Reset during data bit 3 of 0x7F
        entrada_serial = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            entrada_serial = 1'b1;
            repeat (CPB) @(negedge clock);
        end
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {20'd0, dados_ascii, pronto, tem_dado, erro_paridade, erro_stop, erro_overrun},
              32'd0);
        check("midframe_reset_state", {28'd0, db_estado}, 32'd0);
        m_tem = 1'b0;
        m_ovr = 1'b0;
        entrada_serial = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        send_frame(7'h30, 1'b0, 1'b1, 1'b1);
        repeat (6) @(negedge clock);
        pulse_limpa();

        // Randomised frames, gaps, acknowledges and error injection
        for (int n = 0; n < 40; n++) begin
            logic stp;
            bit   bp;
            rd  = 7'($urandom_range(0, 127));
            bp  = ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            send_frame(rd, bp, stp, 1'b1);
            if (!stp) begin
                entrada_serial = 1'b0;
                repeat ($urandom_range(0, 10)) @(negedge clock);
                entrada_serial = 1'b1;
                repeat (6) @(negedge clock);
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat (6) @(negedge clock);
                pulse_limpa();
            end
            gap = $urandom_range(0, 6);
            repeat (gap) @(negedge clock);
        end

        repeat (20) @(negedge clock);
        check("scoreboard_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
